// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encoding and register-file
// addressing constants, also used by the forwarding unit.
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: stall/bubble generation for the
// pipeline registers, data-memory wait tracking with timeout, and perf counters.
//
//   state | meaning
//   IDLE  | no outstanding data-memory access beyond the current cycle
//   WAIT  | access outstanding, front of pipe frozen until ack or timeout
//   ERR   | memory never answered; pipe frozen until reset
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] i_ID_RegAddrRs,
    input  logic [REG_ADDR_W-1:0] i_ID_RegAddrRt,
    input  logic                  i_ID_UseRs,
    input  logic                  i_ID_UseRt,
    input  logic                  i_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] i_EX_RegAddrW,
    input  logic                  i_EX_BranchTaken,
    input  logic                  i_MEM_Req,
    input  logic                  i_MEM_Ack,
    output logic                  o_PC_stall,
    output logic                  o_IFID_stall,
    output logic                  o_IFID_bubble,
    output logic                  o_IDEX_stall,
    output logic                  o_IDEX_bubble,
    output logic                  o_EXMEM_stall,
    output logic                  o_EXMEM_bubble,
    output logic                  o_MEMWB_stall,
    output logic                  o_MEMWB_bubble,
    output logic                  o_Err,
    output logic [CNT_W-1:0]      o_StallCnt,
    output logic [CNT_W-1:0]      o_FlushCnt
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    hz_state_t        state_q, state_d;
    logic [TMO_W-1:0] tmo_q;
    logic             mem_wait;
    logic             load_use;
    logic             flush_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            o_Err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && state_d == ST_WAIT)
                tmo_q <= '0;
            else if (state_q == ST_WAIT && state_d == ST_WAIT)
                tmo_q <= tmo_q + TMO_W'(1);
            if (state_q == ST_WAIT && state_d == ST_ERR)
                o_Err <= 1'b1;
        end
    end

    // An ack always wins, even on the cycle the timeout would expire.
    always_comb begin
        state_d  = state_q;
        mem_wait = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_MEM_Req && !i_MEM_Ack) begin
                    state_d  = ST_WAIT;
                    mem_wait = 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_MEM_Ack) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_wait = 1'b1;
                    if (tmo_q == TMO_LAST)
                        state_d = ST_ERR;
                end
            end
            ST_ERR:  mem_wait = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    assign load_use = i_EX_MemRead && (i_EX_RegAddrW != REG_ZERO) &&
                      ((i_ID_UseRs && (i_ID_RegAddrRs == i_EX_RegAddrW)) ||
                       (i_ID_UseRt && (i_ID_RegAddrRt == i_EX_RegAddrW)));

    always_comb begin
        o_PC_stall     = 1'b0;
        o_IFID_stall   = 1'b0;
        o_IFID_bubble  = 1'b0;
        o_IDEX_stall   = 1'b0;
        o_IDEX_bubble  = 1'b0;
        o_EXMEM_stall  = 1'b0;
        o_EXMEM_bubble = 1'b0;
        o_MEMWB_stall  = 1'b0;
        o_MEMWB_bubble = 1'b0;
        if (rst) begin
            o_IFID_bubble  = 1'b1;
            o_IDEX_bubble  = 1'b1;
            o_EXMEM_bubble = 1'b1;
            o_MEMWB_bubble = 1'b1;
        end else if (mem_wait) begin
            o_PC_stall     = 1'b1;
            o_IFID_stall   = 1'b1;
            o_IDEX_stall   = 1'b1;
            o_EXMEM_stall  = 1'b1;
            o_MEMWB_bubble = 1'b1;
        end else if (i_EX_BranchTaken) begin
            o_IFID_bubble  = 1'b1;
            o_IDEX_bubble  = 1'b1;
        end else if (load_use) begin
            o_PC_stall     = 1'b1;
            o_IFID_stall   = 1'b1;
            o_IDEX_bubble  = 1'b1;
        end
    end

    assign flush_inc = !rst && !mem_wait && i_EX_BranchTaken;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (o_PC_stall),
        .count (o_StallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (o_FlushCnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios plus random
// traffic, checked against a cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // {PC, IFID s/b, IDEX s/b, EXMEM s/b, MEMWB s/b}
    localparam logic [8:0] CTRL_RST  = 9'b0_01_01_01_01;
    localparam logic [8:0] CTRL_MW   = 9'b1_10_10_10_01;
    localparam logic [8:0] CTRL_BR   = 9'b0_01_01_00_00;
    localparam logic [8:0] CTRL_LU   = 9'b1_10_01_00_00;
    localparam logic [8:0] CTRL_NONE = 9'b0_00_00_00_00;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       ex_mr;
        logic [4:0] ex_w;
        logic       br;
        logic       req;
        logic       ack;
    } stim_t;

    typedef struct packed {
        int               id;
        logic [8:0]       ctrl;
        logic             err;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] i_ID_RegAddrRs = '0, i_ID_RegAddrRt = '0, i_EX_RegAddrW = '0;
    logic i_ID_UseRs = 0, i_ID_UseRt = 0, i_EX_MemRead = 0, i_EX_BranchTaken = 0;
    logic i_MEM_Req = 0, i_MEM_Ack = 0;
    logic o_PC_stall, o_IFID_stall, o_IFID_bubble, o_IDEX_stall, o_IDEX_bubble;
    logic o_EXMEM_stall, o_EXMEM_bubble, o_MEMWB_stall, o_MEMWB_bubble, o_Err;
    logic [CNT_W-1:0] o_StallCnt, o_FlushCnt;
    logic [8:0] act_ctrl;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    exp_t exp_q[$];

    // reference model state
    bit m_err, m_pending;
    int m_waited, m_stall, m_flush;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_ID_RegAddrRs   (i_ID_RegAddrRs),
        .i_ID_RegAddrRt   (i_ID_RegAddrRt),
        .i_ID_UseRs       (i_ID_UseRs),
        .i_ID_UseRt       (i_ID_UseRt),
        .i_EX_MemRead     (i_EX_MemRead),
        .i_EX_RegAddrW    (i_EX_RegAddrW),
        .i_EX_BranchTaken (i_EX_BranchTaken),
        .i_MEM_Req        (i_MEM_Req),
        .i_MEM_Ack        (i_MEM_Ack),
        .o_PC_stall       (o_PC_stall),
        .o_IFID_stall     (o_IFID_stall),
        .o_IFID_bubble    (o_IFID_bubble),
        .o_IDEX_stall     (o_IDEX_stall),
        .o_IDEX_bubble    (o_IDEX_bubble),
        .o_EXMEM_stall    (o_EXMEM_stall),
        .o_EXMEM_bubble   (o_EXMEM_bubble),
        .o_MEMWB_stall    (o_MEMWB_stall),
        .o_MEMWB_bubble   (o_MEMWB_bubble),
        .o_Err            (o_Err),
        .o_StallCnt       (o_StallCnt),
        .o_FlushCnt       (o_FlushCnt)
    );

    assign act_ctrl = {o_PC_stall, o_IFID_stall, o_IFID_bubble, o_IDEX_stall, o_IDEX_bubble,
                       o_EXMEM_stall, o_EXMEM_bubble, o_MEMWB_stall, o_MEMWB_bubble};

    task automatic check(input string name, input int id, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", name, id, act, expv);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    // One cycle of the hazard rules: expected outputs for this cycle, then
    // the model state that the following cycle will see.
    task automatic model(input stim_t s, output exp_t e);
        bit mw, lu;
        e.id = cyc;
        if (s.rst) begin
            m_err = 0; m_pending = 0; m_waited = 0; m_stall = 0; m_flush = 0;
            e.ctrl = CTRL_RST; e.err = 1'b0; e.sc = '0; e.fc = '0;
            return;
        end
        e.err = m_err;
        e.sc  = CNT_W'(m_stall);
        e.fc  = CNT_W'(m_flush);
        mw = 0;
        if (m_err) begin
            mw = 1;
        end else if (m_pending) begin
            if (s.ack) begin
                m_pending = 0;
            end else begin
                mw = 1;
                if (m_waited == TIMEOUT - 1) m_err = 1;
                else m_waited++;
            end
        end else if (s.req && !s.ack) begin
            mw = 1;
            m_pending = 1;
            m_waited = 0;
        end
        lu = s.ex_mr && s.ex_w != 0 &&
             ((s.use_rs && s.rs == s.ex_w) || (s.use_rt && s.rt == s.ex_w));
        if (mw)        e.ctrl = CTRL_MW;
        else if (s.br) e.ctrl = CTRL_BR;
        else if (lu)   e.ctrl = CTRL_LU;
        else           e.ctrl = CTRL_NONE;
        if (e.ctrl[8]) m_stall = sat_inc(m_stall);
        if (!mw && s.br) m_flush = sat_inc(m_flush);
    endtask

    task automatic apply(input stim_t s);
        rst              = s.rst;
        i_ID_RegAddrRs   = s.rs;
        i_ID_RegAddrRt   = s.rt;
        i_ID_UseRs       = s.use_rs;
        i_ID_UseRt       = s.use_rt;
        i_EX_MemRead     = s.ex_mr;
        i_EX_RegAddrW    = s.ex_w;
        i_EX_BranchTaken = s.br;
        i_MEM_Req        = s.req;
        i_MEM_Ack        = s.ack;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        apply(s);
        model(s, e);
        exp_q.push_back(e);
    endtask

    // Monitor: every pushed expectation is compared on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ctrl",      e.id, int'(act_ctrl),   int'(e.ctrl));
            check("err",       e.id, int'(o_Err),      int'(e.err));
            check("stall_cnt", e.id, int'(o_StallCnt), int'(e.sc));
            check("flush_cnt", e.id, int'(o_FlushCnt), int'(e.fc));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        stim_t r;
        exp_t  e;

        r = idle();
        r.rst = 1'b1;
        step(r); step(r);

        // load-use on rs, then same with $zero destination
        s = idle(); s.ex_mr = 1; s.ex_w = 5'd8; s.rs = 5'd8; s.use_rs = 1;
        step(s); step(idle());
        s.ex_w = 5'd0; s.rs = 5'd0;
        step(s);
        s = idle(); s.ex_mr = 1; s.ex_w = 5'd3; s.rt = 5'd3; s.use_rt = 1;
        step(s);
        s.use_rt = 0;
        step(s);

        // branch together with load-use
        s = idle(); s.ex_mr = 1; s.ex_w = 5'd8; s.rs = 5'd8; s.use_rs = 1; s.br = 1;
        step(s); step(idle());

        // memory wait, ack on the 4th cycle; then zero-wait access
        s = idle(); s.req = 1;
        step(s); step(s); step(s);
        s.ack = 1;
        step(s);
        step(s);
        step(idle());

        // branch masked by a memory wait must not count as a flush
        s = idle(); s.req = 1; s.br = 1;
        step(s);
        s.ack = 1;
        step(s);

        // drive the stall counter into saturation
        s = idle(); s.ex_mr = 1; s.ex_w = 5'd9; s.rt = 5'd9; s.use_rt = 1;
        for (int i = 0; i < 20; i++) step(s);
        step(idle());
        #2;
        check("stall_saturated", cyc, int'(o_StallCnt), CNT_MAX);

        // timeout into ERR, late ack ignored, reset recovers
        step(r);
        s = idle(); s.req = 1;
        for (int i = 0; i < TIMEOUT + 4; i++) step(s);
        s.ack = 1;
        step(s);
        step(idle());
        #2;
        check("err_sticky", cyc, int'(o_Err), 1);
        check("err_stall_held", cyc, int'(o_PC_stall), 1);
        step(r);
        step(idle());

        // asynchronous reset asserted mid-WAIT, between clock edges
        s = idle(); s.req = 1;
        step(s); step(s); step(s);
        @(posedge clk);
        #1;
        cyc++;
        apply(s);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ctrl",  cyc, int'(act_ctrl),   int'(CTRL_RST));
        check("async_rst_stcnt", cyc, int'(o_StallCnt), 0);
        model(r, e);
        step(r);

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            s        = idle();
            s.rst    = ($urandom_range(0, 59) == 0);
            s.rs     = 5'($urandom_range(0, 3));
            s.rt     = 5'($urandom_range(0, 3));
            s.use_rs = 1'($urandom_range(0, 1));
            s.use_rt = 1'($urandom_range(0, 1));
            s.ex_mr  = 1'($urandom_range(0, 1));
            s.ex_w   = 5'($urandom_range(0, 3));
            s.br     = ($urandom_range(0, 5) == 0);
            s.req    = ($urandom_range(0, 3) == 0);
            s.ack    = ($urandom_range(0, 2) != 0);
            step(s);
        end
        step(idle());

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
